// File: rtl/prog_loader_if.sv
// prog_loader_if: the loader's stream and memory signals in one bundle.
//   Stream : s_valid, s_data[7:0], s_last (source -> loader); s_ready (loader -> source)
//   Memory : mem_addr, mem_en[3:0], mem_we, mem_din (loader -> memory);
//            mem_dout (memory -> loader, valid the cycle after a read)
// Modport master is the loader side, since the loader initiates every memory access.
// Modport slave is the environment side: the byte source plus the memory port.
interface prog_loader_if #(
  parameter int ADDR_W = 14
);
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_en;
  logic              mem_we;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  modport master (
    input  s_valid, s_data, s_last, mem_dout,
    output s_ready, mem_addr, mem_en, mem_we, mem_din
  );

  modport slave (
    output s_valid, s_data, s_last, mem_dout,
    input  s_ready, mem_addr, mem_en, mem_we, mem_din
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot image loader for one port of the program memory.
// Packs a byte stream little-endian into 32-bit words and writes them from
// BASE_ADDR upward. It then reads every word back, sums the read data and
// compares that sum with the sum of the written words. The CPU is held in
// reset until the image verifies.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       begin a load (honoured in IDLE, DONE and ERR only)
//   bus         stream handshake and memory port (prog_loader_if.master)
//   busy        in LOAD / WRITE / VERIFY
//   done        image written and verified
//   error       overflow or verify mismatch
//   word_count  words written during this load
//   checksum    mod-2^32 sum of the written words
//   cpu_hold    CPU reset request, low only in DONE
// Every output is registered. Its next value is decoded from the next state,
// so an output lines up with the state it belongs to.
module prog_loader #(
  parameter int ADDR_W      = 14,
  parameter int DEPTH_WORDS = 16384,
  parameter int BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  prog_loader_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_VRD, S_VCHK, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       pack_q, pack_d;
  logic              last_q, last_d;      // the word being written carried s_last
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [31:0]       sum_q, sum_d;
  logic [ADDR_W:0]   vidx_q, vidx_d;
  logic [31:0]       vsum_q, vsum_d;

  logic              s_ready_q, s_ready_d;
  logic [3:0]        mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic [31:0]       word_nxt;
  logic [31:0]       vsum_nxt;
  logic [ADDR_W:0]   vidx_nxt;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    pack_d     = pack_q;
    last_d     = last_q;
    wc_d       = wc_q;
    sum_d      = sum_q;
    vidx_d     = vidx_q;
    vsum_d     = vsum_q;
    mem_en_d   = 4'h0;
    mem_we_d   = 1'b0;
    mem_addr_d = '0;
    mem_din_d  = 32'h0;

    // Merge the incoming byte into its lane. Lanes not yet filled stay zero,
    // so a short final word is already zero-padded.
    word_nxt = pack_q | ({24'h0, bus.s_data} << {byte_idx_q, 3'b000});
    vsum_nxt = vsum_q + bus.mem_dout;
    vidx_nxt = vidx_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LOAD;
          wc_d       = '0;
          sum_d      = 32'h0;
          byte_idx_d = 2'd0;
          pack_d     = 32'h0;
          last_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.s_valid && s_ready_q) begin
          pack_d     = word_nxt;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3 || bus.s_last) begin
            state_d = S_WRITE;
            last_d  = bus.s_last;
            // Set up the write strobe on entry to WRITE. A full memory
            // leaves the strobe low, so nothing is written.
            if (wc_q != DEPTH) begin
              mem_en_d   = 4'hF;
              mem_we_d   = 1'b1;
              mem_addr_d = BASE + wc_q[ADDR_W-1:0];
              mem_din_d  = word_nxt;
            end
          end
        end
      end
      S_WRITE: begin
        if (wc_q == DEPTH) begin
          state_d = S_ERR;
        end else begin
          wc_d       = wc_q + 1'b1;
          sum_d      = sum_q + pack_q;
          pack_d     = 32'h0;
          byte_idx_d = 2'd0;
          if (last_q) begin
            state_d    = S_VRD;
            vidx_d     = '0;
            vsum_d     = 32'h0;
            mem_en_d   = 4'hF;
            mem_addr_d = BASE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_VRD: begin
        state_d = S_VCHK;
      end
      S_VCHK: begin
        // mem_dout holds the word requested during the previous VRD cycle.
        vsum_d = vsum_nxt;
        vidx_d = vidx_nxt;
        if (vidx_nxt == wc_q) begin
          state_d = (vsum_nxt == sum_q) ? S_DONE : S_ERR;
        end else begin
          state_d    = S_VRD;
          mem_en_d   = 4'hF;
          mem_addr_d = BASE + vidx_nxt[ADDR_W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d  = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE) ||
                 (state_d == S_VRD)  || (state_d == S_VCHK);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      pack_q     <= 32'h0;
      last_q     <= 1'b0;
      wc_q       <= '0;
      sum_q      <= 32'h0;
      vidx_q     <= '0;
      vsum_q     <= 32'h0;
      s_ready_q  <= 1'b0;
      mem_en_q   <= 4'h0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      pack_q     <= pack_d;
      last_q     <= last_d;
      wc_q       <= wc_d;
      sum_q      <= sum_d;
      vidx_q     <= vidx_d;
      vsum_q     <= vsum_d;
      s_ready_q  <= s_ready_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.mem_en   = mem_en_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign word_count   = wc_q;
  assign checksum     = sum_q;
  assign cpu_hold     = cpu_hold_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader. dut0 has full depth and dut1 has DEPTH_WORDS=4.
// Both share the byte stream but have separate start inputs and separate
// memory models. A stream model turns each byte list into expected memory
// writes. Those writes are queued when the stimulus is built, then popped
// and compared when the DUT strobes a write.
module tb_prog_loader;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst, start0, start1;
  logic s_valid, s_last;
  logic [7:0] s_data;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(AW)) bus0();
  prog_loader_if #(.ADDR_W(AW)) bus1();
  assign bus0.s_valid = s_valid;
  assign bus0.s_data  = s_data;
  assign bus0.s_last  = s_last;
  assign bus1.s_valid = s_valid;
  assign bus1.s_data  = s_data;
  assign bus1.s_last  = s_last;

  logic busy0, done0, error0, hold0, busy1, done1, error1, hold1;
  logic [AW:0] wc0, wc1;
  logic [31:0] sum0, sum1;

  prog_loader #(.ADDR_W(AW), .DEPTH_WORDS(16384), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .error(error0),
    .word_count(wc0), .checksum(sum0), .cpu_hold(hold0));

  prog_loader #(.ADDR_W(AW), .DEPTH_WORDS(4), .BASE_ADDR(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .error(error1),
    .word_count(wc1), .checksum(sum1), .cpu_hold(hold1));

  // Memory models. The read data is registered and appears one cycle after a read.
  // When corrupt1 is set, dut0's write to word 1 is stored with bit 0 flipped.
  logic [31:0] mem0 [0:(1<<AW)-1];
  logic [31:0] mem1 [0:(1<<AW)-1];
  logic corrupt1 = 1'b0;
  always @(posedge clk) begin
    if (bus0.mem_en != 4'h0) begin
      if (bus0.mem_we)
        mem0[bus0.mem_addr] <= (corrupt1 && bus0.mem_addr == AW'(1)) ? (bus0.mem_din ^ 32'h1) : bus0.mem_din;
      else
        bus0.mem_dout <= mem0[bus0.mem_addr];
    end
    if (bus1.mem_en != 4'h0) begin
      if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_din;
      else bus1.mem_dout <= mem1[bus1.mem_addr];
    end
  end

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  wr_t exp0[$];
  wr_t exp1[$];
  int checks = 0;
  int errors = 0;
  int en_in_load = 0;
  int bad_en = 0;

  // Write monitor. It samples on the falling edge, away from the registered outputs.
  always @(negedge clk) begin
    wr_t w;
    if (!rst) begin
      if (bus0.mem_en != 4'h0 && bus0.s_ready) en_in_load++;
      if (bus0.mem_en != 4'h0 && bus0.mem_en != 4'hF) bad_en++;
      if (bus1.mem_en != 4'h0 && bus1.mem_en != 4'hF) bad_en++;
      if (bus0.mem_en == 4'hF && bus0.mem_we) begin
        checks++;
        if (exp0.size() == 0) begin
          errors++;
          $display("FAIL wr0_unexpected addr=%h data=%h", bus0.mem_addr, bus0.mem_din);
        end else begin
          w = exp0.pop_front();
          if (bus0.mem_addr !== w.addr || bus0.mem_din !== w.data) begin
            errors++;
            $display("FAIL wr0 got addr=%h data=%h want addr=%h data=%h",
                     bus0.mem_addr, bus0.mem_din, w.addr, w.data);
          end
        end
      end
      if (bus1.mem_en == 4'hF && bus1.mem_we) begin
        checks++;
        if (exp1.size() == 0) begin
          errors++;
          $display("FAIL wr1_unexpected addr=%h data=%h", bus1.mem_addr, bus1.mem_din);
        end else begin
          w = exp1.pop_front();
          if (bus1.mem_addr !== w.addr || bus1.mem_din !== w.data) begin
            errors++;
            $display("FAIL wr1 got addr=%h data=%h want addr=%h data=%h",
                     bus1.mem_addr, bus1.mem_din, w.addr, w.data);
          end
        end
      end
    end
  end

  // Stream model: little-endian packing, zero padding, and no writes past depth.
  task automatic model(input int sel, input logic [7:0] b[$], input bit with_last,
                       input int depth, output logic [31:0] sum, output int wc);
    logic [31:0] w;
    wr_t e;
    sum = 32'h0; wc = 0; w = 32'h0;
    for (int i = 0; i < b.size(); i++) begin
      w = w | (32'(b[i]) << (8 * (i % 4)));
      if (i % 4 == 3 || (with_last && i == b.size() - 1)) begin
        if (wc < depth) begin
          e.addr = AW'(wc); e.data = w;
          if (sel != 0) exp1.push_back(e); else exp0.push_back(e);
          sum += w; wc++;
        end
        w = 32'h0;
      end
    end
  endtask

  task automatic pulse_start(input int sel);
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  task automatic send_stream(input int sel, input logic [7:0] b[$], input bit with_last, input int max_gap);
    int tmo;
    int g;
    for (int i = 0; i < b.size(); i++) begin
      g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      if (g > 0) begin s_valid = 1'b0; repeat (g) @(negedge clk); end
      s_valid = 1'b1; s_data = b[i]; s_last = with_last && (i == b.size() - 1);
      tmo = 0;
      while (!((sel != 0) ? bus1.s_ready : bus0.s_ready) && tmo < 100) begin
        @(negedge clk); tmo++;
      end
      if (tmo >= 100) begin
        checks++; errors++;
        $display("FAIL s_ready_timeout byte=%0d got=0 want=1", i);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_end(input int sel);
    int n;
    n = 0;
    while (!((sel != 0) ? (done1 || error1) : (done0 || error0)) && n < 2000) begin
      @(negedge clk); n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL end_timeout sel=%0d got=busy want=done_or_error", sel);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.s_ready !== 1'b0 || bus0.mem_en !== 4'h0 || bus0.mem_we !== 1'b0 ||
        bus0.mem_addr !== '0 || bus0.mem_din !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got rdy=%b en=%h we=%b addr=%h din=%h want all zero",
               bus0.s_ready, bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.mem_din);
    end
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || error0 !== 1'b0 || hold0 !== 1'b1 ||
        wc0 !== '0 || sum0 !== 32'h0 || hold1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_status got busy=%b done=%b err=%b hold=%b wc=%0d sum=%h want 0 0 0 1 0 0",
               busy0, done0, error0, hold0, wc0, sum0);
    end
  endtask

  task automatic test_basic();
    logic [7:0] b[$];
    logic [31:0] s;
    int wc;
    b = '{8'h93, 8'h80, 8'h10, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    model(0, b, 1'b1, 16384, s, wc);
    pulse_start(0);
    send_stream(0, b, 1'b1, 0);
    wait_end(0);
    checks++;
    if (done0 !== 1'b1 || error0 !== 1'b0 || hold0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_status got done=%b err=%b hold=%b busy=%b want 1 0 0 0", done0, error0, hold0, busy0);
    end
    checks++;
    if (wc0 !== 15'd2 || sum0 !== 32'h001080A6) begin
      errors++;
      $display("FAIL basic_counts got wc=%0d sum=%h want wc=2 sum=001080a6", wc0, sum0);
    end
    checks++;
    if (mem0[0] !== 32'h00108093 || mem0[1] !== 32'h00000013 || exp0.size() != 0) begin
      errors++;
      $display("FAIL basic_mem got %h %h pending=%0d want 00108093 00000013 pending=0",
               mem0[0], mem0[1], exp0.size());
    end
  endtask

  task automatic test_partial();
    logic [7:0] b[$];
    logic [31:0] s;
    int wc;
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    mem0[0] = 32'hFFFFFFFF; mem0[1] = 32'hFFFFFFFF;
    bad_en = 0;
    model(0, b, 1'b1, 16384, s, wc);
    pulse_start(0);
    send_stream(0, b, 1'b1, 0);
    wait_end(0);
    checks++;
    if (mem0[0] !== 32'h44332211 || mem0[1] !== 32'h00000055) begin
      errors++;
      $display("FAIL partial_mem got %h %h want 44332211 00000055", mem0[0], mem0[1]);
    end
    checks++;
    if (wc0 !== 15'd2 || sum0 !== 32'h44332266 || done0 !== 1'b1 || bad_en != 0) begin
      errors++;
      $display("FAIL partial_status got wc=%0d sum=%h done=%b bad_en=%0d want 2 44332266 1 0",
               wc0, sum0, done0, bad_en);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] b[$];
    logic [31:0] s;
    int wc;
    b = '{8'h93, 8'h80, 8'h10, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    mem0[0] = 32'h0; mem0[1] = 32'h0;
    en_in_load = 0;
    model(0, b, 1'b1, 16384, s, wc);
    pulse_start(0);
    send_stream(0, b, 1'b1, 4);
    wait_end(0);
    checks++;
    if (mem0[0] !== 32'h00108093 || mem0[1] !== 32'h00000013 || exp0.size() != 0) begin
      errors++;
      $display("FAIL gaps_mem got %h %h pending=%0d want 00108093 00000013 pending=0",
               mem0[0], mem0[1], exp0.size());
    end
    checks++;
    if (en_in_load != 0 || done0 !== 1'b1 || sum0 !== s) begin
      errors++;
      $display("FAIL gaps_status got en_in_load=%0d done=%b sum=%h want 0 1 %h", en_in_load, done0, sum0, s);
    end
  endtask

  task automatic test_corrupt();
    logic [7:0] b[$];
    logic [31:0] s;
    int wc;
    b = '{8'h93, 8'h80, 8'h10, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    corrupt1 = 1'b1;
    model(0, b, 1'b1, 16384, s, wc);
    pulse_start(0);
    send_stream(0, b, 1'b1, 0);
    wait_end(0);
    corrupt1 = 1'b0;
    checks++;
    if (error0 !== 1'b1 || done0 !== 1'b0 || hold0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL corrupt_status got err=%b done=%b hold=%b busy=%b want 1 0 1 0", error0, done0, hold0, busy0);
    end
    checks++;
    if (wc0 !== 15'd2 || sum0 !== 32'h001080A6) begin
      errors++;
      $display("FAIL corrupt_counts got wc=%0d sum=%h want 2 001080a6", wc0, sum0);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b[$];
    logic [31:0] s;
    int wc;
    for (int i = 1; i <= 17; i++) b.push_back(8'(i));
    mem1[4] = 32'hDEADBEEF;
    model(1, b, 1'b1, 4, s, wc);
    pulse_start(1);
    send_stream(1, b, 1'b1, 0);
    wait_end(1);
    checks++;
    if (error1 !== 1'b1 || done1 !== 1'b0 || hold1 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_status got err=%b done=%b hold=%b want 1 0 1", error1, done1, hold1);
    end
    checks++;
    if (wc1 !== 15'd4 || sum1 !== 32'h2824201C || exp1.size() != 0) begin
      errors++;
      $display("FAIL ovf_counts got wc=%0d sum=%h pending=%0d want 4 2824201c 0", wc1, sum1, exp1.size());
    end
    checks++;
    if (mem1[0] !== 32'h04030201 || mem1[3] !== 32'h100F0E0D || mem1[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ovf_mem got %h %h %h want 04030201 100f0e0d deadbeef", mem1[0], mem1[3], mem1[4]);
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] b[$];
    logic [7:0] p[$];
    logic [31:0] s;
    int wc;
    b = '{8'h93, 8'h80, 8'h10, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    p = '{8'h93, 8'h80, 8'h10, 8'h00, 8'h13, 8'h00};
    model(0, p, 1'b0, 16384, s, wc);
    pulse_start(0);
    send_stream(0, p, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (wc0 !== '0 || sum0 !== 32'h0 || busy0 !== 1'b0 || hold0 !== 1'b1 || bus0.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear got wc=%0d sum=%h busy=%b hold=%b rdy=%b want 0 0 0 1 0",
               wc0, sum0, busy0, hold0, bus0.s_ready);
    end
    mem0[0] = 32'h0; mem0[1] = 32'h0;
    model(0, b, 1'b1, 16384, s, wc);
    pulse_start(0);
    send_stream(0, b, 1'b1, 0);
    wait_end(0);
    checks++;
    if (done0 !== 1'b1 || wc0 !== 15'd2 || sum0 !== 32'h001080A6 || exp0.size() != 0) begin
      errors++;
      $display("FAIL rstmid_result got done=%b wc=%0d sum=%h pending=%0d want 1 2 001080a6 0",
               done0, wc0, sum0, exp0.size());
    end
    checks++;
    if (mem0[0] !== 32'h00108093 || mem0[1] !== 32'h00000013) begin
      errors++;
      $display("FAIL rstmid_mem got %h %h want 00108093 00000013", mem0[0], mem0[1]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_partial();
    test_gaps();
    test_corrupt();
    test_overflow();
    test_rst_mid();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
